// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller.
//
// Contents:
//   REG_AW_MAX   widest register address the slot records can hold
//   FWD_RF       forwarding select value meaning "use register-file data"
//   reg_addr_t   register address as stored in the tracker slots
//   stage_slot_t post-EX stage record {valid, rd, regwrite}
//   ex_slot_t    EX stage record {valid, rs, rt, rd, regwrite, memread, multi}
//   fwd_width()  width of a forwarding select for a given number of post-EX stages
package pipe_ctrl_pkg;

    // Register addresses narrower than this are zero-extended into the slots,
    // so equality compares stay exact for any REG_AW up to this value.
    localparam int REG_AW_MAX = 8;

    localparam int FWD_RF = 0;

    typedef logic [REG_AW_MAX-1:0] reg_addr_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t rd;
        logic      regwrite;
    } stage_slot_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t rs;
        reg_addr_t rt;
        reg_addr_t rd;
        logic      regwrite;
        logic      memread;
        logic      multi;
    } ex_slot_t;

    // One code per forwarding stage plus the register-file code.
    function automatic int fwd_width(input int post_stages);
        return (post_stages < 1) ? 1 : $clog2(post_stages + 1);
    endfunction

endpackage

// File: rtl/pipe_fwd_select.sv
// Priority search over the post-EX stage slots for one EX source register.
//
// Ports:
//   src_valid  EX holds a real instruction
//   src        EX source register address
//   slots      post-EX slots, index 0 = stage 1 (nearest to EX)
//   sel        smallest matching stage number, or FWD_RF when none matches
module pipe_fwd_select
    import pipe_ctrl_pkg::*;
#(
    parameter int POST_STAGES = 2,
    parameter int FWD_W       = fwd_width(POST_STAGES)
) (
    input  logic                          src_valid,
    input  reg_addr_t                     src,
    input  stage_slot_t [POST_STAGES-1:0] slots,
    output logic        [FWD_W-1:0]       sel
);

    // Scan from the oldest stage towards EX so the nearest match overwrites
    // any older one; register 0 is hard-wired and never forwards.
    always_comb begin
        sel = FWD_W'(FWD_RF);
        for (int k = POST_STAGES; k >= 1; k--) begin
            if (src_valid && slots[k-1].valid && slots[k-1].regwrite &&
                (slots[k-1].rd != '0) && (slots[k-1].rd == src)) begin
                sel = FWD_W'(k);
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and stall controller for the in-order pipeline.
// Tracks destination registers through EX and POST_STAGES later stages,
// selects EX operand forwarding sources, and produces the PC, IF/ID and
// ID/EX enables. Multi-cycle EX ops hold EX for MUL_LAT cycles.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   id_*                      decoded instruction currently in ID
//   pc_write, ifid_write      front-end enables (low while stalling)
//   ifid_flush                squash IF/ID after a taken redirect
//   idex_write, idex_bubble   ID/EX enable and zero-control insert
//   ex_hold                   EX busy with an unfinished multi-cycle op
//   fwd_a, fwd_b              EX operand sources (0 = register file, k = stage k)
//   stall_cnt                 saturating count of stall cycles
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter  int REG_AW      = 5,
    parameter  int POST_STAGES = 2,
    parameter  int MUL_LAT     = 4,
    parameter  int CNT_W       = 16,
    localparam int FWD_W       = fwd_width(POST_STAGES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_multi,
    input  logic              id_redirect,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_write,
    output logic              idex_bubble,
    output logic              ex_hold,
    output logic [FWD_W-1:0]  fwd_a,
    output logic [FWD_W-1:0]  fwd_b,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int BCNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [BCNT_W-1:0] BCNT_LOAD = BCNT_W'(MUL_LAT - 1);

    ex_slot_t                      ex_q;
    stage_slot_t [POST_STAGES-1:0] post_q;
    logic        [BCNT_W-1:0]      bcnt_q;
    ex_slot_t                      id_slot;
    reg_addr_t                     id_rs_w;
    reg_addr_t                     id_rt_w;
    reg_addr_t                     id_rd_w;
    logic                          load_use;
    logic                          stall;

    assign id_rs_w = reg_addr_t'(id_rs);
    assign id_rt_w = reg_addr_t'(id_rt);
    assign id_rd_w = reg_addr_t'(id_rd);

    assign ex_hold = ex_q.valid & ex_q.multi & (bcnt_q != '0);

    assign load_use = id_valid & ex_q.valid & ex_q.memread & ex_q.regwrite &
                      (ex_q.rd != '0) &
                      ((id_uses_rs & (id_rs_w == ex_q.rd)) |
                       (id_uses_rt & (id_rt_w == ex_q.rd)));

    assign stall = ex_hold | load_use;

    // A redirect seen while stalled is dropped; the branch is still in ID
    // next cycle and resolves again once the stall clears.
    assign pc_write    = ~stall;
    assign ifid_write  = ~stall;
    assign idex_write  = ~ex_hold;
    assign idex_bubble = load_use & ~ex_hold;
    assign ifid_flush  = id_redirect & ~stall;

    // What EX would capture from ID this cycle; a load-use stall turns it into a bubble.
    assign id_slot = '{valid:    id_valid & ~load_use,
                       rs:       id_rs_w,
                       rt:       id_rt_w,
                       rd:       id_rd_w,
                       regwrite: id_regwrite,
                       memread:  id_memread,
                       multi:    id_multi};

    // Destination tracker: while EX is held its occupant stays put and a
    // bubble leaves towards stage 1, otherwise everything advances one stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q   <= '0;
            post_q <= '0;
        end else begin
            if (ex_hold) begin
                post_q[0] <= '0;
            end else begin
                post_q[0] <= '{valid: ex_q.valid, rd: ex_q.rd, regwrite: ex_q.regwrite};
                ex_q      <= id_slot;
            end
            for (int k = 1; k < POST_STAGES; k++) begin
                post_q[k] <= post_q[k-1];
            end
        end
    end

    // Busy counter: the entry cycle plus MUL_LAT-1 held cycles gives a
    // multi-cycle op exactly MUL_LAT cycles in EX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt_q <= '0;
        end else if (!ex_hold && id_slot.valid && id_multi) begin
            bcnt_q <= BCNT_LOAD;
        end else if (bcnt_q != '0) begin
            bcnt_q <= bcnt_q - 1'b1;
        end
    end

    // Stall cycle counter, sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    pipe_fwd_select #(
        .POST_STAGES (POST_STAGES),
        .FWD_W       (FWD_W)
    ) u_fwd_a (
        .src_valid (ex_q.valid),
        .src       (ex_q.rs),
        .slots     (post_q),
        .sel       (fwd_a)
    );

    pipe_fwd_select #(
        .POST_STAGES (POST_STAGES),
        .FWD_W       (FWD_W)
    ) u_fwd_b (
        .src_valid (ex_q.valid),
        .src       (ex_q.rt),
        .slots     (post_q),
        .sel       (fwd_b)
    );

endmodule
